bnn_layer_ctrl: RTL and testbench

BNN_LAYER_CTRL -- requirements
Module: bnn_layer_ctrl

---
 rtl/bnn_layer_ctrl.sv | 151 +++++++++++++++
 tb/tb_bnn_layer_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bnn_layer_ctrl
// Brief   : Binary neural-network layer sequencer (XNOR/popcount/threshold)
// Revision: 1.0
// ============================================================================
module bnn_layer_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  cfg_rows,
  input  logic [5:0]  cfg_bits,
  input  logic [5:0]  cfg_thresh,
  input  logic [31:0] act_word,
  output logic        w_req,
  output logic [4:0]  w_addr,
  input  logic        w_valid,
  input  logic [31:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  localparam logic [5:0] MAX_DIM = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  rows_q, rows_d;
  logic [5:0]  bits_q, bits_d;
  logic [5:0]  thresh_q, thresh_d;
  logic [31:0] act_q, act_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        w_cfg_legal;
  logic [31:0] w_mask;
  logic [31:0] w_diff;
  logic [5:0]  w_mism;
  logic [5:0]  w_match;
  logic        w_bit;
  logic        w_last_row;

  assign w_cfg_legal = (cfg_rows != 6'd0) && (cfg_rows <= MAX_DIM) &&
                       (cfg_bits != 6'd0) && (cfg_bits <= MAX_DIM) &&
                       (cfg_thresh <= cfg_bits);

  // 33-bit shift so that bits_q == 32 yields an all-ones mask.
  assign w_mask  = 32'((33'd1 << bits_q) - 33'd1);
  assign w_diff  = (w_data ^ act_q) & w_mask;

  always_comb begin
    w_mism = 6'd0;
    for (int i = 0; i < 32; i++) begin
      w_mism = w_mism + {5'd0, w_diff[i]};
    end
  end

  assign w_match    = bits_q - w_mism;
  assign w_bit      = (w_match >= thresh_q);
  assign w_last_row = ({1'b0, row_q} == (rows_q - 6'd1));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    rows_d   = rows_q;
    bits_d   = bits_q;
    thresh_d = thresh_q;
    act_d    = act_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_legal) begin
            rows_d   = cfg_rows;
            bits_d   = cfg_bits;
            thresh_d = cfg_thresh;
            act_d    = act_word;
            row_d    = 5'd0;
            result_d = 32'd0;
            state_d  = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // Abort takes priority over a coincident weight beat.
        if (abort) begin
          result_d = 32'd0;
          row_d    = 5'd0;
          state_d  = S_IDLE;
        end else if (w_valid) begin
          result_d[row_q] = w_bit;
          if (w_last_row) begin
            state_d = S_DONE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        row_d   = 5'd0;
        state_d = S_IDLE;
      end
      default: begin
        row_d   = 5'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= 5'd0;
      rows_q   <= 6'd0;
      bits_q   <= 6'd0;
      thresh_q <= 6'd0;
      act_q    <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rows_q   <= rows_d;
      bits_q   <= bits_d;
      thresh_q <= thresh_d;
      act_q    <= act_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign w_req  = (state_q == S_FETCH);
  assign w_addr = row_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bnn_layer_ctrl
// Brief   : Directed self-checking bench for bnn_layer_ctrl
// Revision: 1.0
// ============================================================================
module tb_bnn_layer_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [5:0]  cfg_rows;
  logic [5:0]  cfg_bits;
  logic [5:0]  cfg_thresh;
  logic [31:0] act_word;
  logic        w_req;
  logic [4:0]  w_addr;
  logic        w_valid;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  logic [31:0] wmem [0:31];
  int n_cmp;
  int n_fail;

  bnn_layer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_rows   (cfg_rows),
    .cfg_bits   (cfg_bits),
    .cfg_thresh (cfg_thresh),
    .act_word   (act_word),
    .w_req      (w_req),
    .w_addr     (w_addr),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder for one pass; called at a negedge, returns at a negedge in IDLE.
  task automatic do_pass(input logic [5:0] rows, input logic [5:0] bits,
                         input logic [5:0] thresh, input logic [31:0] act,
                         input int waits, input bit mid_start,
                         output int done_cyc, output int accepted, output bit addr_ok);
    int wcnt;
    addr_ok  = 1'b1;
    accepted = 0;
    done_cyc = -1;
    wcnt     = 0;
    cfg_rows = rows; cfg_bits = bits; cfg_thresh = thresh; act_word = act;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        w_valid  = 1'b0;
        break;
      end
      if (mid_start && cyc == 2) begin
        start = 1'b1; cfg_rows = 6'd1; cfg_thresh = 6'd0; act_word = ~act;
      end else begin
        start = 1'b0;
      end
      w_valid = 1'b0;
      if (w_req === 1'b1) begin
        if (w_addr !== accepted[4:0]) addr_ok = 1'b0;
        if (wcnt < waits) begin
          wcnt++;
        end else begin
          wcnt    = 0;
          w_valid = 1'b1;
          w_data  = wmem[w_addr];
          accepted++;
        end
      end
      @(negedge clk);
    end
    w_valid = 1'b0;
    start   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = 32'd0;
    cfg_rows = 6'd0; cfg_bits = 6'd0; cfg_thresh = 6'd0; act_word = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({w_req, busy, done, err, w_addr, result} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b err=%b addr=%0d res=%h want all 0",
               w_req, busy, done, err, w_addr, result);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_two_row();
    int dc, acc; bit aok;
    wmem[0] = 32'h167; wmem[1] = 32'h000;
    do_pass(6'd2, 6'd9, 6'd5, 32'h1E5, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h1) begin
      n_fail++; $display("FAIL two_row_result: got %h want 00000001", result);
    end
    n_cmp++;
    if (dc !== 3) begin
      n_fail++; $display("FAIL two_row_latency: got %0d want 3", dc);
    end
    n_cmp++;
    if (!aok || acc != 2) begin
      n_fail++; $display("FAIL two_row_addr_seq: got ok=%0d accepted=%0d want ok=1 accepted=2", aok, acc);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL two_row_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_threshold();
    int dc, acc; bit aok;
    // High garbage above bit 8 in both operands must not matter.
    wmem[0] = 32'h1234_5755;
    do_pass(6'd1, 6'd9, 6'd3, 32'hABCD_E0CE, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h1) begin
      n_fail++; $display("FAIL thresh3_result: got %h want 00000001", result);
    end
    n_cmp++;
    if (dc !== 2) begin
      n_fail++; $display("FAIL thresh3_latency: got %0d want 2", dc);
    end
    wmem[0] = 32'h155;
    do_pass(6'd1, 6'd9, 6'd4, 32'h0CE, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL thresh4_result: got %h want 00000000", result);
    end
  endtask

  task automatic test_illegal();
    int dc, acc; bit aok;
    wmem[0] = 32'h167; wmem[1] = 32'h000;
    do_pass(6'd2, 6'd9, 6'd5, 32'h1E5, 0, 1'b0, dc, acc, aok);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        cfg_rows = 6'd0; cfg_bits = 6'd9; cfg_thresh = 6'd3;
      end else begin
        cfg_rows = 6'd1; cfg_bits = 6'd9; cfg_thresh = 6'd10;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || w_req !== 1'b0 || result !== 32'h1) begin
        n_fail++;
        $display("FAIL illegal%0d_pulse: got err=%b busy=%b req=%b res=%h want 1 0 0 00000001",
                 k, err, busy, w_req, result);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_width: got err=%b busy=%b want 0 0", k, err, busy);
      end
    end
  endtask

  task automatic test_wait_busy();
    int dc, acc; bit aok;
    wmem[0] = 32'hF; wmem[1] = 32'h0; wmem[2] = 32'h3;
    do_pass(6'd3, 6'd4, 6'd2, 32'hF, 3, 1'b1, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h5) begin
      n_fail++; $display("FAIL wait_result: got %h want 00000005", result);
    end
    n_cmp++;
    if (dc !== 13 || acc != 3) begin
      n_fail++; $display("FAIL wait_latency: got cyc=%0d accepted=%0d want 13 3", dc, acc);
    end
    n_cmp++;
    if (!aok) begin
      n_fail++; $display("FAIL wait_addr_stable: got ok=0 want ok=1");
    end
  endtask

  task automatic test_full_width();
    int dc, acc; bit aok;
    for (int i = 0; i < 32; i++) wmem[i] = 32'hA5A5A5A5;
    do_pass(6'd32, 6'd32, 6'd32, 32'hA5A5A5A5, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'hFFFFFFFF || dc !== 33) begin
      n_fail++; $display("FAIL full_match: got res=%h cyc=%0d want ffffffff 33", result, dc);
    end
    for (int i = 0; i < 32; i++) wmem[i] = 32'h5A5A5A5A;
    do_pass(6'd32, 6'd32, 6'd32, 32'hA5A5A5A5, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h0 || !aok) begin
      n_fail++; $display("FAIL full_mismatch: got res=%h addr_ok=%0d want 00000000 1", result, aok);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    saw_done = 1'b0;
    for (int i = 0; i < 32; i++) wmem[i] = 32'h0;
    cfg_rows = 6'd8; cfg_bits = 6'd32; cfg_thresh = 6'd0; act_word = 32'hFFFF0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      w_valid = 1'b1; w_data = wmem[w_addr];
      @(negedge clk);
    end
    n_cmp++;
    if (w_addr !== 5'd5 || result !== 32'h1F) begin
      n_fail++; $display("FAIL abort_pre: got addr=%0d res=%h want 5 0000001f", w_addr, result);
    end
    abort = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; w_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || w_req !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b req=%b res=%h done=%b want 0 0 00000000 0",
               busy, w_req, result, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_fail++; $display("FAIL abort_no_done: got done pulse want none");
    end
  endtask

  task automatic test_reset_midpass();
    int dc, acc; bit aok;
    for (int i = 0; i < 32; i++) wmem[i] = 32'h0;
    cfg_rows = 6'd16; cfg_bits = 6'd32; cfg_thresh = 6'd0; act_word = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      w_valid = 1'b1; w_data = wmem[w_addr];
      @(negedge clk);
    end
    w_valid = 1'b0;
    n_cmp++;
    if (w_addr !== 5'd10 || result !== 32'h3FF) begin
      n_fail++; $display("FAIL rst_pre: got addr=%0d res=%h want 10 000003ff", w_addr, result);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({w_req, busy, done, err, w_addr, result} !== 41'd0) begin
      n_fail++;
      $display("FAIL rst_async: got req=%b busy=%b done=%b err=%b addr=%0d res=%h want all 0",
               w_req, busy, done, err, w_addr, result);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wmem[0] = 32'h167; wmem[1] = 32'h000;
    do_pass(6'd2, 6'd9, 6'd5, 32'h1E5, 0, 1'b0, dc, acc, aok);
    n_cmp++;
    if (result !== 32'h1 || dc !== 3 || !aok) begin
      n_fail++; $display("FAIL rst_recover: got res=%h cyc=%0d addr_ok=%0d want 00000001 3 1",
                         result, dc, aok);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_two_row();
    test_threshold();
    test_illegal();
    test_wait_busy();
    test_full_width();
    test_abort();
    test_reset_midpass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
